ps2_tx: RTL and testbench

PS2_TX -- requirements
Module: ps2_tx

---
 rtl/common.sv | 36 +++
 rtl/ps2_filter.sv | 36 +++
 rtl/ps2_tx.sv | 153 +++++++++++++++
 tb/tb_ps2_tx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/common.sv
// Shared PS/2 definitions: host-transmit FSM states, debounce depth and frame helpers.
package common;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_REQ       = 3'd2;
  localparam logic [2:0] ST_DATA      = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  typedef enum logic [2:0] {
    TX_IDLE      = ST_IDLE,
    TX_INHIBIT   = ST_INHIBIT,
    TX_REQ       = ST_REQ,
    TX_DATA      = ST_DATA,
    TX_ACK       = ST_ACK,
    TX_WAIT_IDLE = ST_WAIT_IDLE
  } ps2_tx_state_t;

  localparam int unsigned PS2_DEBOUNCE_LEN = 8;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  // Bit placed on the line after falling edge idx+1: data LSB first, parity, then stop.
  function automatic logic frame_bit(input logic [7:0] d, input logic par, input logic [3:0] idx);
    if (idx < 4'd8)
      return d[idx[2:0]];
    else if (idx == 4'd8)
      return par;
    else
      return 1'b1;
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// Two-flop synchronizer, 8-sample debounce and falling-edge strobe for one PS/2 line.
// Latency ~11 cycles from raw line change to strobe; no backpressure.
module ps2_filter
  import common::*;
(
  input  logic clk28,
  input  logic rst,
  input  logic line_raw,
  output logic line_filt,
  output logic line_fall
);

  logic [1:0]                  sync_q;
  logic [PS2_DEBOUNCE_LEN-1:0] hist_q;
  logic                        filt_prev_q;

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      sync_q      <= 2'b11;
      hist_q      <= '1;
      line_filt   <= 1'b1;
      filt_prev_q <= 1'b1;
    end else begin
      sync_q      <= {sync_q[0], line_raw};
      hist_q      <= {hist_q[PS2_DEBOUNCE_LEN-2:0], sync_q[1]};
      if (&hist_q)
        line_filt <= 1'b1;
      else if (~|hist_q)
        line_filt <= 1'b0;
      filt_prev_q <= line_filt;
    end
  end

  assign line_fall = filt_prev_q & ~line_filt;

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, 10 device-clocked bits, ACK.
// Optional frame timeout when PS2_TX_TIMEOUT_EN is defined; tx_valid is only taken in IDLE.
module ps2_tx
  import common::*;
#(
  parameter int unsigned CLK_FREQ = 28_000_000
)
(
  input  logic       clk28,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned INHIBIT_CYC = CLK_FREQ / 10000;
  localparam int unsigned REQ_CYC     = CLK_FREQ / 1000000;
`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned TIMEOUT_CYC = CLK_FREQ / 50;
  localparam int unsigned TMR_MAX     = TIMEOUT_CYC;
`else
  localparam int unsigned TMR_MAX     = INHIBIT_CYC;
`endif
  localparam int unsigned TMR_W       = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] INHIBIT_LAST = TMR_W'(INHIBIT_CYC - 1);
  localparam logic [TMR_W-1:0] REQ_LAST     = TMR_W'(REQ_CYC - 1);

  ps2_tx_state_t    state_q;
  logic [TMR_W-1:0] tmr_q;
  logic [3:0]       edge_cnt_q;
  logic [7:0]       data_q;
  logic             parity_q;
  logic             dat_bit_oe_q;

  logic clk_filt, clk_fall, dat_filt, dat_fall;
  logic unused_dat_fall;

  ps2_filter u_clk_filter (
    .clk28     (clk28),
    .rst       (rst),
    .line_raw  (ps2_clk_in),
    .line_filt (clk_filt),
    .line_fall (clk_fall)
  );

  ps2_filter u_dat_filter (
    .clk28     (clk28),
    .rst       (rst),
    .line_raw  (ps2_dat_in),
    .line_filt (dat_filt),
    .line_fall (dat_fall)
  );

  assign unused_dat_fall = dat_fall;

  logic accept, inhibit_end, req_end, ack_seen, in_frame, timeout;

  assign accept      = tx_valid && tx_ready;
  assign inhibit_end = (state_q == TX_INHIBIT) && (tmr_q == INHIBIT_LAST);
  assign req_end     = (state_q == TX_REQ) && (tmr_q == REQ_LAST);
  assign ack_seen    = (state_q == TX_ACK) && clk_fall;
  assign in_frame    = (state_q == TX_DATA) || (state_q == TX_ACK) || (state_q == TX_WAIT_IDLE);

`ifdef PS2_TX_TIMEOUT_EN
  assign timeout = in_frame && (tmr_q == TMR_W'(TIMEOUT_CYC));
`else
  assign timeout = 1'b0;
`endif

  // done wins over a coincident timeout so the two pulses never overlap.
  assign done  = (state_q == TX_WAIT_IDLE) && clk_filt && dat_filt;
  assign error = ((ack_seen && dat_filt) || timeout) && !done;

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      state_q      <= TX_IDLE;
      tmr_q        <= '0;
      edge_cnt_q   <= 4'd0;
      data_q       <= 8'h00;
      parity_q     <= 1'b0;
      dat_bit_oe_q <= 1'b0;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (accept) begin
            data_q     <= tx_data;
            parity_q   <= odd_parity(tx_data);
            tmr_q      <= '0;
            edge_cnt_q <= 4'd0;
            state_q    <= TX_INHIBIT;
          end
        end
        TX_INHIBIT: begin
          if (inhibit_end) begin
            tmr_q   <= '0;
            state_q <= TX_REQ;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        TX_REQ: begin
          if (req_end) begin
            tmr_q        <= '0;
            dat_bit_oe_q <= 1'b1;
            edge_cnt_q   <= 4'd0;
            state_q      <= TX_DATA;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        TX_DATA: begin
          if (clk_fall) begin
            dat_bit_oe_q <= ~frame_bit(data_q, parity_q, edge_cnt_q);
            edge_cnt_q   <= edge_cnt_q + 4'd1;
            if (edge_cnt_q == 4'd9)
              state_q <= TX_ACK;
          end
        end
        TX_ACK: begin
          if (ack_seen)
            state_q <= dat_filt ? TX_IDLE : TX_WAIT_IDLE;
        end
        TX_WAIT_IDLE: begin
          if (done)
            state_q <= TX_IDLE;
        end
        default: state_q <= TX_IDLE;
      endcase

`ifdef PS2_TX_TIMEOUT_EN
      // Frame timer reuses the inhibit/request counter, which is idle once DATA starts.
      if (in_frame)
        tmr_q <= tmr_q + 1'b1;
`endif
      if (timeout)
        state_q <= TX_IDLE;
    end
  end

  assign ps2_clk_oe = (state_q == TX_INHIBIT) || (state_q == TX_REQ);
  assign ps2_dat_oe = (state_q == TX_REQ) || ((state_q == TX_DATA) && dat_bit_oe_q);
  assign tx_ready   = (state_q == TX_IDLE) && !rst;
  assign busy       = (state_q != TX_IDLE);

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx with an open-drain PS/2 device model.
module tb_ps2_tx;

  logic       clk28 = 1'b0;
  logic       rst;
  logic       dev_clk, dev_dat;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, busy, done, error;

  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_tx dut (
    .clk28      (clk28),
    .rst        (rst),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk28 = ~clk28;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_err    = 0;
  int n_both   = 0;
  logic pulse_prev  = 1'b0;
  logic ready_after = 1'b0;
  logic [10:0] bits;

  always @(negedge clk28) begin
    if (pulse_prev) ready_after = tx_ready;
    pulse_prev = done | error;
    if (done) n_done++;
    if (error) n_err++;
    if (done && error) n_both++;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk28);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic wait_data(input string tag);
    int k = 0;
    while (!(busy && !ps2_clk_oe) && k < 10000) begin
      tick();
      k++;
    end
    check(tag, (k < 10000) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Device clocks n_edges falling edges; line data is sampled at the end of each high phase.
  task automatic dev_frame(input int half, input int n_edges, input bit ack_low, output logic [10:0] fb);
    fb = '1;
    for (int i = 0; i < n_edges; i++) begin
      dev_clk = 1'b1;
      tick(half);
      fb[i] = ps2_dat_in;
      if (i == 10) begin
        dev_dat = ack_low ? 1'b0 : 1'b1;
        tick(5);
      end
      dev_clk = 1'b0;
      tick(half);
    end
    dev_clk = 1'b1;
    if (n_edges == 11) begin
      tick(half);
      dev_dat = 1'b1;
      tick(40);
    end
  endtask

  initial begin
`ifdef PS2_TX_TIMEOUT_EN
    #20_000_000;
`else
    #2_000_000;
`endif
    n_fail++;
    $display("FAIL watchdog: observed no completion expected end of sequence");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, nd, ne;
    rst = 1'b1; dev_clk = 1'b1; dev_dat = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    #3;
    check("rst_clk_oe",   ps2_clk_oe, 0);
    check("rst_dat_oe",   ps2_dat_oe, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_busy_done_err", {busy, done, error}, 0);
    tick(3);
    rst = 1'b0;
    tick();
    check("idle_tx_ready", tx_ready, 1);
    check("idle_busy", busy, 0);

    // 0x00: inhibit/request timing, then a fast device frame
    send(8'h00);
    check("acc_busy", busy, 1);
    check("acc_tx_ready", tx_ready, 0);
    n = 0;
    while (ps2_clk_oe && !ps2_dat_oe && n < 5000) begin n++; tick(); end
    check("inhibit_cycles", n, 2800);
    n = 0;
    while (ps2_clk_oe && ps2_dat_oe && n < 5000) begin n++; tick(); end
    check("req_cycles", n, 28);
    check("data_clk_oe", ps2_clk_oe, 0);
    check("data_start_bit", ps2_dat_oe, 1);
    ready_after = 1'b0;
    dev_frame(40, 11, 1'b1, bits);
    check("bits_00", bits, 11'h600);
    check("done_00", n_done, 1);
    check("err_00", n_err, 0);
    check("ready_after_done", ready_after, 1);

    // 0xED at 12.5 kHz device clock
    send(8'hED);
    wait_data("wait_ed");
    dev_frame(1120, 11, 1'b1, bits);
    check("bits_ed", bits, 11'h7DA);
    check("done_ed", n_done, 2);
    check("err_ed", n_err, 0);

    // device withholds ACK
    send(8'h5A);
    wait_data("wait_5a");
    ready_after = 1'b0;
    dev_frame(40, 11, 1'b0, bits);
    check("bits_5a", bits, 11'h6B4);
    check("noack_err", n_err, 1);
    check("noack_done", n_done, 2);
    check("ready_after_err", ready_after, 1);

    // clock glitch and ignored tx_valid during DATA
    send(8'hA5);
    wait_data("wait_a5");
    tick(20);
    check("pre_glitch_dat_oe", ps2_dat_oe, 1);
    dev_clk = 1'b0;
    tick(3);
    dev_clk = 1'b1;
    tick(30);
    check("post_glitch_dat_oe", ps2_dat_oe, 1);
    send(8'h00);
    check("busy_tx_ready", tx_ready, 0);
    dev_frame(40, 11, 1'b1, bits);
    check("bits_a5", bits, 11'h74A);
    check("done_a5", n_done, 3);
    tick(50);
    check("no_queue_busy", busy, 0);

    // silent device
    send(8'h11);
    wait_data("wait_11");
`ifdef PS2_TX_TIMEOUT_EN
    n = 0;
    while (!error && n < 600000) begin tick(); n++; end
    check("timeout_cycles", n, 560000);
    check("timeout_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
    check("timeout_err", n_err, 2);
`else
    tick(3000);
    check("stuck_busy", busy, 1);
    check("stuck_err", n_err, 1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
`endif
    tick();
    check("recover_tx_ready", tx_ready, 1);

    // reset after falling edge 5
    send(8'h00);
    wait_data("wait_rst");
    dev_frame(40, 5, 1'b1, bits);
    check("mid_dat_oe", ps2_dat_oe, 1);
    check("mid_busy", busy, 1);
    nd = n_done;
    ne = n_err;
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
    check("mid_rst_outs", {tx_ready, busy, done, error}, 0);
    tick(3);
    rst = 1'b0;
    tick();
    check("mid_rst_ready", tx_ready, 1);
    check("mid_rst_pulses", {n_done - nd, n_err - ne}, 0);

    send(8'hFF);
    wait_data("wait_ff");
    dev_frame(40, 11, 1'b1, bits);
    check("bits_ff", bits, 11'h7FE);
    check("done_ff", n_done - nd, 1);
    check("err_ff", n_err - ne, 0);
    check("done_err_overlap", n_both, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
